// File: rtl/seq_contador_arb_pkg.sv
// seq_contador_arb_pkg: shared FSM state encoding, requester indices and arbiter pick helper
package seq_contador_arb_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;
    // With both requesting, favour whoever was not served last.
    function automatic logic pick(input logic [1:0] req, input logic rr_last);
        return (req == 2'b11) ? ~rr_last : req[REQ1];
    endfunction
endpackage

// File: rtl/seq_contador_arb_contador.sv
// contador_nbit: WIDTH-bit up-counter, synchronous clear has priority over enable
module contador_nbit #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q + WIDTH'(1);
endmodule

// File: rtl/seq_contador_arb.sv
// seq_contador_arb: round-robin arbiter sharing one up-counter between two requesters
module seq_contador_arb
    import seq_contador_arb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int STEPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [STEPW-1:0] steps0,
    input  logic [STEPW-1:0] steps1,
    input  logic             clear0,
    input  logic             clear1,
    output logic [1:0]       gnt,
    output logic             w,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       done,
    output logic             busy
);
    state_t           state;
    logic             owner;
    logic             rr_last;
    logic             clr_flag;
    logic [STEPW-1:0] remaining;
    logic             nxt_owner;
    logic [1:0]       owner_oh;

    assign nxt_owner = pick(req, rr_last);
    assign owner_oh  = owner ? 2'b10 : 2'b01;
    assign busy      = state != S_IDLE;
    assign gnt       = busy ? owner_oh : 2'b00;
    assign w         = state == S_RUN;
    assign done      = (state == S_DONE) ? owner_oh : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            clr_flag  <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (|req) begin
                        owner     <= nxt_owner;
                        remaining <= nxt_owner ? steps1 : steps0;
                        clr_flag  <= nxt_owner ? clear1 : clear0;
                        state     <= S_LOAD;
                    end
                S_LOAD:
                    state <= (remaining == '0) ? S_DONE : S_RUN;
                S_RUN: begin
                    remaining <= remaining - STEPW'(1);
                    if (remaining == STEPW'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    rr_last <= owner;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    contador_nbit #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (w),
        .clr ((state == S_LOAD) && clr_flag),
        .q   (y)
    );
endmodule

// File: tb/tb_seq_contador_arb.sv
// tb_seq_contador_arb: directed and random transactions checked against a transaction-level model
module tb_seq_contador_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] steps0 = '0, steps1 = '0;
    logic       clear0 = 1'b0, clear1 = 1'b0;
    logic [1:0] gnt, done;
    logic       w, busy;
    logic [2:0] y;

    int checks = 0;
    int fails  = 0;
    int m_y    = 0;
    int m_rr   = 1;

    seq_contador_arb dut (
        .clk(clk), .rst(rst), .req(req), .steps0(steps0), .steps1(steps1),
        .clear0(clear0), .clear1(clear1), .gnt(gnt), .w(w), .y(y),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction from an IDLE cycle; model picks owner and predicts every cycle.
    task automatic serve(input logic [1:0] r, input int s0, input int s1, input bit c0, input bit c1);
        int own, n;
        bit c;
        logic [1:0] oh;
        req = r; steps0 = 4'(s0); steps1 = 4'(s1); clear0 = c0; clear1 = c1;
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        own = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : 1 - m_rr;
        n   = own ? s1 : s0;
        c   = own ? c1 : c0;
        oh  = own ? 2'b10 : 2'b01;
        @(negedge clk);
        chk("load_gnt", gnt, oh);
        chk("load_w", w, 0);
        chk("load_y", y, m_y);
        chk("load_busy", busy, 1);
        // Post-grant input changes must be ignored
        req = 2'($urandom); steps0 = 4'($urandom); steps1 = 4'($urandom);
        clear0 = 1'($urandom); clear1 = 1'($urandom);
        if (c) m_y = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("run_w", w, 1);
            chk("run_gnt", gnt, oh);
            chk("run_y", y, m_y);
            chk("run_done", done, 0);
            m_y = (m_y + 1) % 8;
        end
        @(negedge clk);
        chk("done_pulse", done, oh);
        chk("done_gnt", gnt, oh);
        chk("done_w", w, 0);
        chk("done_y", y, m_y);
        m_rr = own;
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_y", y, m_y);
    endtask

    initial begin
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_w", w, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", y, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        serve(2'b01, 3, 0, 1, 0);
        serve(2'b10, 0, 0, 0, 0);
        serve(2'b01, 6, 0, 1, 0);
        serve(2'b01, 4, 0, 0, 0);
        repeat (4) serve(2'b11, 1, 1, 0, 0);
        // Reset in the third RUN cycle aborts silently
        req = 2'b01; steps0 = 4'd5; clear0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_w", w, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_y", y, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_w", w, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        m_y = 0;
        m_rr = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        serve(2'b11, 2, 3, 0, 0);
        serve(2'b10, 0, 2, 0, 1);
        serve(2'b01, 2, 9, 0, 0);
        serve(2'b11, 2, 1, 0, 0);
        for (int i = 0; i < 25; i++)
            serve(2'($urandom_range(3, 1)), $urandom_range(15, 0), $urandom_range(15, 0),
                  1'($urandom), 1'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
